safe_game_ctrl: RTL and testbench

SAFE_GAME_CTRL -- requirements
Module: safe_game_ctrl

---
 rtl/safe_pkg.sv | 48 ++++
 rtl/safe_score.sv | 100 ++++++++++
 rtl/safe_game_ctrl.sv | 145 ++++++++++++++
 tb/tb_safe_game_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : safe_pkg
//  Description : Shared types, constants and helpers for the safe game
//                controller: game state enum, digit/code types, scoring
//                length and small arithmetic helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package safe_pkg;

    // One combination digit; values above 9 are legal and compared raw
    typedef logic [3:0] digit_t;

    // Four-digit code, index [3] is the leftmost digit
    typedef digit_t [3:0] code_t;

    // Top-level game states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_SCORE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Number of clock cycles spent scoring one guess
    localparam int SCORE_CYCLES = 5;

    // Population count of a 4-bit mask, returned at counter width
    function automatic logic [3:0] count_ones(input logic [3:0] v);
        return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]};
    endfunction

    // Two-digit BCD increment that saturates at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/safe_score.sv
`default_nettype none
// ============================================================================
//  Module      : safe_score
//  Description : Multi-cycle guess scorer. A start pulse begins a fixed-length
//                run: step 0 marks exact matches, steps 1..4 resolve guess
//                positions 3..0 against unused non-exact secret digits. done
//                pulses on the last step with the final counts presented
//                combinationally so the caller can capture them on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module safe_score
    import safe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  code_t      secret,
    input  code_t      guess,
    output logic       done,
    output logic [3:0] correct,
    output logic [3:0] misplaced
);

    localparam logic [2:0] LAST_STEP = 3'(SCORE_CYCLES - 1);

    logic       running;
    logic [2:0] step;
    logic [3:0] exact;
    logic [3:0] used;
    logic [3:0] correct_cnt;
    logic [3:0] misplaced_cnt;

    logic [3:0] exact_now;
    logic [1:0] pos;
    logic       hit;
    logic [1:0] hit_idx;

    // Position-wise equality of guess and secret digits
    for (genvar i = 0; i < 4; i++) begin : g_exact
        assign exact_now[i] = (secret[i] == guess[i]);
    end

    // Steps 1..4 walk guess positions from leftmost (3) to rightmost (0)
    always_comb begin
        pos = 2'(3'd4 - step);
    end

    // Find the lowest-index secret digit still free to pair with this position
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        if (running && (step != 3'd0) && !exact[pos]) begin
            for (int j = 0; j < 4; j++) begin
                if (!hit && !exact[j] && !used[j] && (secret[j] == guess[pos])) begin
                    hit     = 1'b1;
                    hit_idx = 2'(j);
                end
            end
        end
    end

    assign done      = running && (step == LAST_STEP);
    assign correct   = correct_cnt;
    // Include the final step's match so results are complete while done is high
    assign misplaced = misplaced_cnt + {3'b000, hit};

    // Step sequencer and scoring registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running       <= 1'b0;
            step          <= 3'd0;
            exact         <= 4'd0;
            used          <= 4'd0;
            correct_cnt   <= 4'd0;
            misplaced_cnt <= 4'd0;
        end else if (start) begin
            running       <= 1'b1;
            step          <= 3'd0;
            exact         <= 4'd0;
            used          <= 4'd0;
            correct_cnt   <= 4'd0;
            misplaced_cnt <= 4'd0;
        end else if (running) begin
            if (step == 3'd0) begin
                exact       <= exact_now;
                correct_cnt <= count_ones(exact_now);
            end else if (hit) begin
                used[hit_idx] <= 1'b1;
                misplaced_cnt <= misplaced_cnt + 4'd1;
            end
            if (done) begin
                running <= 1'b0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/safe_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : safe_game_ctrl
//  Description : Code-breaking safe game controller. Detects rising edges of
//                enter and secret_load, sequences IDLE/PLAY/SCORE/WIN/LOSE,
//                keeps the BCD try counter and publishes score results.
//  Revision    : 1.0 - initial release
// ============================================================================
module safe_game_ctrl
    import safe_pkg::*;
#(
    parameter int MAX_TRIES = 10
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0][3:0] secret,
    input  logic            secret_load,
    input  logic [3:0][3:0] guess,
    input  logic            enter,
    output logic [3:0][3:0] guess_q,
    output logic [3:0]      nCorrect,
    output logic [3:0]      nMisplaced,
    output logic [1:0][3:0] tries,
    output logic            win,
    output logic            lose,
    output logic            busy
);

    // Try limit expressed in the same BCD form as the counter
    localparam logic [7:0] MAX_BCD = {4'(MAX_TRIES / 10), 4'(MAX_TRIES % 10)};

    state_t     state;
    state_t     state_next;

    logic       enter_q;
    logic       load_q;
    logic       enter_edge;
    logic       load_edge;
    code_t      secret_q;

    logic       do_load;
    logic       do_enter;

    logic       score_done;
    logic [3:0] score_correct;
    logic [3:0] score_misplaced;
    logic [7:0] tries_inc;

    assign enter_edge = enter & ~enter_q;
    assign load_edge  = secret_load & ~load_q;
    assign tries_inc  = bcd_inc(tries);

    assign win  = (state == ST_WIN);
    assign lose = (state == ST_LOSE);
    assign busy = (state == ST_SCORE);

    safe_score u_score (
        .clk       (clk),
        .reset     (reset),
        .start     (do_enter),
        .secret    (secret_q),
        .guess     (guess_q),
        .done      (score_done),
        .correct   (score_correct),
        .misplaced (score_misplaced)
    );

    // Game state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; edges that the current state does not accept are dropped
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_enter   = 1'b0;
        case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (load_edge) begin
                    do_load    = 1'b1;
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (enter_edge) begin
                    do_enter   = 1'b1;
                    state_next = ST_SCORE;
                end
            end
            ST_SCORE: begin
                if (score_done) begin
                    if (score_correct == 4'd4) begin
                        state_next = ST_WIN;
                    end else if (tries_inc == MAX_BCD) begin
                        state_next = ST_LOSE;
                    end else begin
                        state_next = ST_PLAY;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Edge-detect history, secret/guess capture, counter and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q    <= 1'b0;
            load_q     <= 1'b0;
            secret_q   <= '0;
            guess_q    <= '0;
            nCorrect   <= 4'd0;
            nMisplaced <= 4'd0;
            tries      <= '0;
        end else begin
            enter_q <= enter;
            load_q  <= secret_load;
            if (do_load) begin
                secret_q   <= secret;
                guess_q    <= '0;
                nCorrect   <= 4'd0;
                nMisplaced <= 4'd0;
                tries      <= '0;
            end
            if (do_enter) begin
                guess_q <= guess;
            end
            if ((state == ST_SCORE) && score_done) begin
                nCorrect   <= score_correct;
                nMisplaced <= score_misplaced;
                tries      <= tries_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_safe_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_safe_game_ctrl
//  Description : Self-checking bench for safe_game_ctrl. A behavioural game
//                model predicts every output each cycle; directed scenarios
//                add literal expectations, then randomized play follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_safe_game_ctrl;

    localparam int MAX_TRIES = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0][3:0] secret = '0;
    logic            secret_load = 1'b0;
    logic [3:0][3:0] guess = '0;
    logic            enter = 1'b0;
    logic [3:0][3:0] guess_q;
    logic [3:0]      nCorrect;
    logic [3:0]      nMisplaced;
    logic [1:0][3:0] tries;
    logic            win;
    logic            lose;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;

    safe_game_ctrl #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk         (clk),
        .reset       (reset),
        .secret      (secret),
        .secret_load (secret_load),
        .guess       (guess),
        .enter       (enter),
        .guess_q     (guess_q),
        .nCorrect    (nCorrect),
        .nMisplaced  (nMisplaced),
        .tries       (tries),
        .win         (win),
        .lose        (lose),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for a secret, 1 guessing, 2 scoring, 3 won, 4 lost
    int          m_mode = 0;
    int          m_left = 0;
    logic [15:0] m_secret = '0;
    logic [15:0] m_guess = '0;
    int          m_correct = 0;
    int          m_mis = 0;
    int          m_tries = 0;
    logic        m_prev_enter = 1'b0;
    logic        m_prev_load = 1'b0;

    // Mastermind-style score: exact matches first, then left-to-right pairing
    function automatic void score(input logic [15:0] s, input logic [15:0] g,
                                  output int c, output int m);
        bit ex[4];
        bit used[4];
        bit found;
        c = 0;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            ex[i]   = (s[i*4 +: 4] == g[i*4 +: 4]);
            used[i] = 1'b0;
            if (ex[i]) c++;
        end
        for (int i = 3; i >= 0; i--) begin
            if (!ex[i]) begin
                found = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (!found && !ex[j] && !used[j] && s[j*4 +: 4] == g[i*4 +: 4]) begin
                        found   = 1'b1;
                        used[j] = 1'b1;
                        m++;
                    end
                end
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_left = 0; m_secret = '0; m_guess = '0;
            m_correct = 0; m_mis = 0; m_tries = 0;
            m_prev_enter = 1'b0; m_prev_load = 1'b0;
        end else begin
            bit ent_e;
            bit ld_e;
            ent_e = enter && !m_prev_enter;
            ld_e  = secret_load && !m_prev_load;
            if (m_mode == 0 || m_mode == 3 || m_mode == 4) begin
                if (ld_e) begin
                    m_secret = secret; m_guess = '0; m_tries = 0;
                    m_correct = 0; m_mis = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (ent_e) begin
                    m_guess = guess; m_mode = 2; m_left = 5;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    score(m_secret, m_guess, m_correct, m_mis);
                    if (m_tries < 99) m_tries++;
                    if (m_correct == 4)             m_mode = 3;
                    else if (m_tries == MAX_TRIES)  m_mode = 4;
                    else                            m_mode = 1;
                end
            end
            m_prev_enter = enter;
            m_prev_load  = secret_load;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("m_guess_q",    16'(guess_q),    m_guess);
        check("m_nCorrect",   16'(nCorrect),   16'(m_correct));
        check("m_nMisplaced", 16'(nMisplaced), 16'(m_mis));
        check("m_tries",      16'(tries),      {8'h00, 4'(m_tries / 10), 4'(m_tries % 10)});
        check("m_win",        16'(win),        16'(m_mode == 3));
        check("m_lose",       16'(lose),       16'(m_mode == 4));
        check("m_busy",       16'(busy),       16'(m_mode == 2));
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_secret(input logic [15:0] s);
        secret = s;
        secret_load = 1'b1;
        @(negedge clk);
        secret_load = 1'b0;
        @(negedge clk);
    endtask

    // Pulse enter and return at the first sample where results are visible
    task automatic submit(input logic [15:0] g);
        guess = g;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_code();
        logic [15:0] c;
        for (int i = 0; i < 4; i++) begin
            c[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, 3));
        end
        return c;
    endfunction

    logic [7:0] tries_before;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_win",   16'(win),        16'd0);
        check("rst_lose",  16'(lose),       16'd0);
        check("rst_busy",  16'(busy),       16'd0);
        check("rst_tries", 16'(tries),      16'd0);
        check("rst_corr",  16'(nCorrect),   16'd0);
        check("rst_guess", 16'(guess_q),    16'd0);
        reset = 1'b0;
        @(negedge clk);

        // Exact guess: win with latency of 6 cycles after the enter edge
        load_secret(16'h1234);
        guess = 16'h1234;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (4) @(negedge clk);
        check("lat_busy",  16'(busy),     16'd1);
        check("lat_hold",  16'(nCorrect), 16'd0);
        @(negedge clk);
        check("w_corr",  16'(nCorrect),   16'd4);
        check("w_mis",   16'(nMisplaced), 16'd0);
        check("w_tries", 16'(tries),      16'h01);
        check("w_win",   16'(win),        16'd1);
        check("w_busy",  16'(busy),       16'd0);

        // All digits misplaced, back to guessing
        load_secret(16'h1234);
        submit(16'h4321);
        check("r_corr",  16'(nCorrect),   16'd0);
        check("r_mis",   16'(nMisplaced), 16'd4);
        check("r_tries", 16'(tries),      16'h01);
        check("r_win",   16'(win),        16'd0);
        check("r_lose",  16'(lose),       16'd0);

        // Duplicate digits in the guess: leftmost 1 exact, one 2 misplaced
        submit(16'h1122);
        check("d_corr",  16'(nCorrect),   16'd1);
        check("d_mis",   16'(nMisplaced), 16'd1);
        check("d_tries", 16'(tries),      16'h02);
        submit(16'h1234);
        check("d_win",   16'(win),        16'd1);

        // Secret 1123 vs 3111: position 2 is exact (1/1); the 3 and one 1 pair up
        load_secret(16'h1123);
        submit(16'h3111);
        check("e_corr", 16'(nCorrect),   16'd1);
        check("e_mis",  16'(nMisplaced), 16'd2);
        submit(16'h1123);

        // Raw comparison of digits above 9
        load_secret(16'hFA12);
        submit(16'hAF12);
        check("h_corr", 16'(nCorrect),   16'd2);
        check("h_mis",  16'(nMisplaced), 16'd2);
        submit(16'hFA12);

        // Run out of tries
        load_secret(16'h1234);
        for (int k = 0; k < MAX_TRIES; k++) submit(16'h5555);
        check("l_tries", 16'(tries), 16'h10);
        check("l_lose",  16'(lose),  16'd1);
        check("l_win",   16'(win),   16'd0);
        submit(16'h1234);
        check("l_ign_tries", 16'(tries), 16'h10);
        check("l_ign_lose",  16'(lose),  16'd1);
        load_secret(16'h1234);
        check("l_new_tries", 16'(tries), 16'h00);
        check("l_new_lose",  16'(lose),  16'd0);

        // Enter held high produces a single scored guess
        tries_before = tries;
        guess = 16'h5555;
        enter = 1'b1;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_tries", 16'(tries), 16'h01);

        // Second enter edge during scoring is dropped
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (8) @(negedge clk);
        check("drop_tries", 16'(tries), 16'h02);
        check("drop_busy",  16'(busy),  16'd0);

        // Reset in the middle of scoring (third scoring cycle)
        guess = 16'h1234;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("ar_busy",  16'(busy),     16'd0);
        check("ar_tries", 16'(tries),    16'd0);
        check("ar_guess", 16'(guess_q),  16'd0);
        check("ar_corr",  16'(nCorrect), 16'd0);
        check("ar_win",   16'(win),      16'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        // Back in IDLE: an enter is ignored
        submit(16'h1234);
        check("ar_idle_busy", 16'(busy),  16'd0);
        check("ar_idle_win",  16'(win),   16'd0);
        check("ar_idle_try",  16'(tries), 16'd0);

        // Randomized play checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            #1;
            reset       = ($urandom_range(0, 599) == 0);
            enter       = ($urandom_range(0, 2) == 0);
            secret_load = ($urandom_range(0, 7) == 0);
            secret      = rand_code();
            guess       = ($urandom_range(0, 3) == 0) ? m_secret : rand_code();
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        enter = 1'b0;
        secret_load = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
